// File: rtl/div_unit_iter_pkg.sv
// ----------------------------------------------------------------------------
// div_unit_iter_pkg
// Purpose : Shared definitions for the iterative divide unit. Holds the ALU
//           control codes seen by the execute stage, the divider FSM state
//           encoding and a small decode helper.
// Contents: ALU_* codes       5-bit ALU control encodings from decode
//           div_state_t       DIV_IDLE / DIV_BUSY / DIV_DONE
//           isDivCode()       true for either divide code
// ----------------------------------------------------------------------------
package div_unit_iter_pkg;

    // ALU control encodings produced by instruction decode.
    localparam logic [4:0] ALU_ADD          = 5'b00000;
    localparam logic [4:0] ALU_SUB          = 5'b00001;
    localparam logic [4:0] ALU_AND          = 5'b00010;
    localparam logic [4:0] ALU_OR           = 5'b00011;
    localparam logic [4:0] ALU_SIGNED_MULT  = 5'b01010;
    localparam logic [4:0] ALU_UNSIGNED_MULT = 5'b01011;
    localparam logic [4:0] ALU_SIGNED_DIV   = 5'b01100;
    localparam logic [4:0] ALU_UNSIGNED_DIV = 5'b01101;

    // Divider sequencing states.
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    // Only the two divide codes are handled by this unit; everything else
    // stays in the combinational ALU.
    function automatic logic isDivCode(input logic [4:0] code);
        return (code == ALU_SIGNED_DIV) || (code == ALU_UNSIGNED_DIV);
    endfunction

endpackage

// File: rtl/div_unit_iter_if.sv
// ----------------------------------------------------------------------------
// div_unit_iter_if
// Purpose : Groups the execute-stage request signals and the divider's
//           stall/result signals into one bundle.
// Signals : alu_controlE  ALU code of the E-stage instruction
//           validE        E-stage slot holds a real instruction
//           flushE        kill any divide in progress
//           holdE         E stage held by another stall source
//           srcaE/srcbE   dividend / divisor
//           div_stall     freeze IF..E while the divide runs
//           div_done      hi_out/lo_out valid, qualifies HI/LO write
//           hi_out/lo_out remainder / quotient
// Modports: master = pipeline side, slave = divide unit
// ----------------------------------------------------------------------------
interface div_unit_iter_if #(
    parameter int DATA_W = 32
);

    logic [4:0]        alu_controlE;
    logic              validE;
    logic              flushE;
    logic              holdE;
    logic [DATA_W-1:0] srcaE;
    logic [DATA_W-1:0] srcbE;
    logic              div_stall;
    logic              div_done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;

    modport master (
        output alu_controlE, validE, flushE, holdE, srcaE, srcbE,
        input  div_stall, div_done, hi_out, lo_out
    );

    modport slave (
        input  alu_controlE, validE, flushE, holdE, srcaE, srcbE,
        output div_stall, div_done, hi_out, lo_out
    );

endinterface

// File: rtl/div_unit_iter_step.sv
// ----------------------------------------------------------------------------
// div_step
// Purpose : One combinational radix-2 restoring division iteration.
//           Shifts the next dividend bit into the partial remainder and
//           subtracts the divisor when that does not borrow.
// Ports   : i_rem      partial remainder (always < divisor when divisor != 0)
//           i_divisor  divisor magnitude
//           i_bit      next dividend bit, MSB first
//           o_rem      updated partial remainder
//           o_qBit     quotient bit produced by this step
// ----------------------------------------------------------------------------
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rem,
    input  logic [DATA_W-1:0] i_divisor,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_rem,
    output logic              o_qBit
);

    logic [DATA_W:0]   w_shifted;
    logic [DATA_W+1:0] w_diff;
    logic              w_unusedBit;

    // The subtraction is two bits wider than the divisor so the MSB is a
    // clean borrow flag even when the shifted remainder needs DATA_W+1 bits.
    assign w_shifted = {i_rem, i_bit};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, i_divisor};
    assign o_qBit    = ~w_diff[DATA_W+1];

    // Restore (keep the shifted value) when the trial subtraction borrowed.
    assign o_rem = o_qBit ? w_diff[DATA_W-1:0] : w_shifted[DATA_W-1:0];

    // On a successful subtract the result is below the divisor, so this bit
    // is never needed.
    assign w_unusedBit = w_diff[DATA_W];

endmodule

// File: rtl/div_unit_iter.sv
// ----------------------------------------------------------------------------
// div_unit_iter
// Purpose : Execute-stage iterative divider for the signed/unsigned divide
//           ALU codes. Runs one restoring step per cycle for DATA_W cycles,
//           stalls the pipeline meanwhile, then presents
//           {hi = remainder, lo = quotient} for the HI/LO write.
// Ports   : clk     rising-edge clock
//           resetn  asynchronous active-low reset
//           bus     div_unit_iter_if.slave (request in, stall/result out)
// Notes   : Divide by zero takes the full latency and yields
//           lo = all-ones, hi = dividend. The most-negative / -1 case wraps
//           naturally to lo = most-negative, hi = 0.
// ----------------------------------------------------------------------------
module div_unit_iter
    import div_unit_iter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    div_unit_iter_if.slave bus
);

    localparam int              CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    div_state_t        r_state;
    div_state_t        w_nextState;
    logic              w_start;
    logic              w_stall;
    logic              w_done;
    logic              w_isSigned;
    logic              w_signA;
    logic              w_signB;
    logic [DATA_W-1:0] w_magA;
    logic [DATA_W-1:0] w_magB;

    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic [CNT_W-1:0]  r_count;
    logic              r_negQ;
    logic              r_negR;
    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;

    logic [DATA_W-1:0] w_newRem;
    logic              w_qBit;
    logic [DATA_W-1:0] w_finalQuo;
    logic [DATA_W-1:0] w_fixQ;
    logic [DATA_W-1:0] w_fixR;
    logic              w_lastStep;

    // Operand magnitudes. Negation is plain DATA_W-bit two's complement, so
    // the most-negative value maps onto itself and is then treated as an
    // unsigned magnitude.
    assign w_isSigned = (bus.alu_controlE == ALU_SIGNED_DIV);
    assign w_signA    = w_isSigned & bus.srcaE[DATA_W-1];
    assign w_signB    = w_isSigned & bus.srcbE[DATA_W-1];
    assign w_magA     = w_signA ? -bus.srcaE : bus.srcaE;
    assign w_magB     = w_signB ? -bus.srcbE : bus.srcbE;

    // The dividend magnitude lives in r_quo and is shifted out MSB first
    // while quotient bits are shifted in at the bottom.
    div_step #(
        .DATA_W (DATA_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_divisor (r_div),
        .i_bit     (r_quo[DATA_W-1]),
        .o_rem     (w_newRem),
        .o_qBit    (w_qBit)
    );

    assign w_finalQuo = {r_quo[DATA_W-2:0], w_qBit};
    assign w_lastStep = (r_count == LAST_STEP);

    // Sign fix-up applied on the way into the result registers. For a zero
    // divisor the quotient keeps its all-ones pattern, while the remainder
    // (equal to |dividend|) regains the dividend's sign, giving hi = dividend.
    assign w_fixQ = r_negQ ? -w_finalQuo : w_finalQuo;
    assign w_fixR = r_negR ? -w_newRem   : w_newRem;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake outputs. A flush overrides everything: it
    // forces IDLE, masks a same-cycle start and hides div_done.
    always_comb begin
        w_nextState = r_state;
        w_start     = 1'b0;
        w_stall     = 1'b0;
        w_done      = 1'b0;

        w_start = (r_state == DIV_IDLE) & bus.validE & ~bus.flushE &
                  isDivCode(bus.alu_controlE);

        case (r_state)
            DIV_IDLE: begin
                if (w_start) begin
                    w_nextState = DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                if (w_lastStep) begin
                    w_nextState = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (!bus.holdE) begin
                    w_nextState = DIV_IDLE;
                end
            end
            default: begin
                w_nextState = DIV_IDLE;
            end
        endcase

        if (bus.flushE) begin
            w_nextState = DIV_IDLE;
        end

        w_stall = (w_start | (r_state == DIV_BUSY)) & ~bus.flushE;
        w_done  = (r_state == DIV_DONE) & ~bus.flushE;
    end

    // Datapath: operands are captured only on start, so later changes on
    // srcaE/srcbE are invisible. Results load on the final step unless the
    // divide is being flushed, leaving the previous hi/lo untouched.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_count <= '0;
            r_negQ  <= 1'b0;
            r_negR  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            if (w_start) begin
                r_rem   <= '0;
                r_quo   <= w_magA;
                r_div   <= w_magB;
                r_count <= '0;
                r_negQ  <= (w_signA ^ w_signB) & (bus.srcbE != '0);
                r_negR  <= w_signA;
            end else if ((r_state == DIV_BUSY) && !bus.flushE) begin
                r_rem   <= w_newRem;
                r_quo   <= w_finalQuo;
                r_count <= r_count + 1'b1;
                if (w_lastStep) begin
                    r_lo <= w_fixQ;
                    r_hi <= w_fixR;
                end
            end
        end
    end

    assign bus.div_stall = w_stall;
    assign bus.div_done  = w_done;
    assign bus.hi_out    = r_hi;
    assign bus.lo_out    = r_lo;

endmodule

// File: tb/tb_div_unit_iter.sv
// ----------------------------------------------------------------------------
// tb_div_unit_iter
// Self-checking bench for div_unit_iter: a table of fixed divides with
// hand-computed results, randomized divides against an arithmetic reference
// model, and hand-written sequences for flush, hold, non-divide codes and
// asynchronous reset.
// ----------------------------------------------------------------------------
module tb_div_unit_iter;
    import div_unit_iter_pkg::*;

    localparam int W = 32;

    logic clk    = 1'b0;
    logic resetn = 1'b0;

    always #5 clk = ~clk;

    div_unit_iter_if #(.DATA_W(W)) bus();

    div_unit_iter #(
        .DATA_W (W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expLo;
        logic [W-1:0] expHi;
    } vec_t;

    vec_t vecs [10];

    // Compare one value and report a failure line on mismatch.
    task automatic checkOutput(input string name, input logic [W-1:0] actual,
                               input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, actual, expected);
        end
    endtask

    // Reference divide from plain integer arithmetic.
    function automatic void refModel(input logic [4:0] code, input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     output logic [W-1:0] lo, output logic [W-1:0] hi);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 0) begin
            lo = '1;
            hi = a;
        end else if (code == ALU_UNSIGNED_DIV) begin
            lo = a / b;
            hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = '0;
        end else begin
            lo = sa / sb;
            hi = sa % sb;
        end
    endfunction

    // Present one divide starting now (just after a rising edge), then count
    // stall cycles until div_done, with a bounded wait. Returns one cycle
    // after the done cycle, again just after a rising edge.
    task automatic applyStimulus(input logic [4:0] code, input logic [W-1:0] a,
                                 input logic [W-1:0] b, output int stalls,
                                 output logic gotDone, output logic [W-1:0] lo,
                                 output logic [W-1:0] hi);
        bus.alu_controlE = code;
        bus.validE       = 1'b1;
        bus.srcaE        = a;
        bus.srcbE        = b;
        stalls  = 0;
        gotDone = 1'b0;
        lo      = '0;
        hi      = '0;
        for (int c = 0; c < W + 20; c++) begin
            @(negedge clk);
            if (bus.div_done) begin
                gotDone = 1'b1;
                lo      = bus.lo_out;
                hi      = bus.hi_out;
                break;
            end
            if (bus.div_stall) stalls++;
            @(posedge clk);
            #1;
            bus.validE = 1'b0;
            bus.srcaE  = $urandom;
            bus.srcbE  = $urandom;
        end
        @(posedge clk);
        #1;
        bus.validE = 1'b0;
    endtask

    // Run one divide and check result, stall length and completion.
    task automatic runAndCheck(input string tag, input logic [4:0] code,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] expLo, input logic [W-1:0] expHi);
        int           stalls;
        logic         gotDone;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        applyStimulus(code, a, b, stalls, gotDone, lo, hi);
        checkOutput($sformatf("%s done", tag), {31'd0, gotDone}, 32'd1);
        checkOutput($sformatf("%s lo", tag), lo, expLo);
        checkOutput($sformatf("%s hi", tag), hi, expHi);
        checkOutput($sformatf("%s stallCycles", tag), stalls, W + 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [W-1:0] expLo;
        logic [W-1:0] expHi;
        logic [W-1:0] prevLo;
        logic [W-1:0] prevHi;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [4:0]   rc;
        int           sawDone;
        int           sawStall;

        vecs[0] = '{ALU_UNSIGNED_DIV, 32'd100,        32'd7,        32'd14,         32'd2};
        vecs[1] = '{ALU_SIGNED_DIV,   32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF};
        vecs[2] = '{ALU_SIGNED_DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
        vecs[3] = '{ALU_UNSIGNED_DIV, 32'd5,          32'd0,        32'hFFFF_FFFF,  32'd5};
        vecs[4] = '{ALU_SIGNED_DIV,   32'hFFFF_FFF9,  32'd0,        32'hFFFF_FFFF,  32'hFFFF_FFF9};
        vecs[5] = '{ALU_SIGNED_DIV,   32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
        vecs[6] = '{ALU_UNSIGNED_DIV, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{ALU_UNSIGNED_DIV, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[8] = '{ALU_SIGNED_DIV,   32'h8000_0000,  32'd1,        32'h8000_0000,  32'd0};
        vecs[9] = '{ALU_UNSIGNED_DIV, 32'd0,          32'd9,        32'd0,          32'd0};

        bus.alu_controlE = ALU_ADD;
        bus.validE       = 1'b0;
        bus.flushE       = 1'b0;
        bus.holdE        = 1'b0;
        bus.srcaE        = '0;
        bus.srcbE        = '0;

        // Reset state.
        #2;
        checkOutput("reset div_stall", {31'd0, bus.div_stall}, 32'd0);
        checkOutput("reset div_done",  {31'd0, bus.div_done},  32'd0);
        checkOutput("reset hi_out",    bus.hi_out, 32'd0);
        checkOutput("reset lo_out",    bus.lo_out, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Table of fixed vectors.
        for (int i = 0; i < 10; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].code, vecs[i].a, vecs[i].b,
                        vecs[i].expLo, vecs[i].expHi);
        end

        // Randomized divides against the reference model.
        for (int i = 0; i < 30; i++) begin
            rc = ($urandom_range(0, 1) == 0) ? ALU_SIGNED_DIV : ALU_UNSIGNED_DIV;
            ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = 32'($urandom_range(1, 65535));
                default: rb = 32'($urandom);
            endcase
            refModel(rc, ra, rb, expLo, expHi);
            runAndCheck($sformatf("rand%0d", i), rc, ra, rb, expLo, expHi);
        end

        // Known state before the corner sequences: 100 / 7 leaves lo=14, hi=2.
        runAndCheck("pre", ALU_UNSIGNED_DIV, 32'd100, 32'd7, 32'd14, 32'd2);
        prevLo = 32'd14;
        prevHi = 32'd2;

        // Flush in BUSY cycle 10: stall drops immediately, no done ever.
        bus.alu_controlE = ALU_UNSIGNED_DIV;
        bus.srcaE        = 32'd1000;
        bus.srcbE        = 32'd3;
        bus.validE       = 1'b1;
        @(negedge clk);
        checkOutput("flush start stall", {31'd0, bus.div_stall}, 32'd1);
        @(posedge clk);
        #1;
        bus.validE = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        checkOutput("flush busy stall", {31'd0, bus.div_stall}, 32'd1);
        bus.flushE = 1'b1;
        #1;
        checkOutput("flush same-cycle stall", {31'd0, bus.div_stall}, 32'd0);
        checkOutput("flush same-cycle done",  {31'd0, bus.div_done},  32'd0);
        @(posedge clk);
        #1;
        bus.flushE = 1'b0;
        sawDone  = 0;
        sawStall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.div_done)  sawDone++;
            if (bus.div_stall) sawStall++;
        end
        checkOutput("flush done never", sawDone, 0);
        checkOutput("flush idle no stall", sawStall, 0);
        checkOutput("flush lo kept", bus.lo_out, prevLo);
        checkOutput("flush hi kept", bus.hi_out, prevHi);
        @(posedge clk);
        #1;

        // Flush coinciding with a start suppresses the divide.
        bus.alu_controlE = ALU_SIGNED_DIV;
        bus.validE       = 1'b1;
        bus.flushE       = 1'b1;
        @(negedge clk);
        checkOutput("flush+start stall", {31'd0, bus.div_stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.validE = 1'b0;
        bus.flushE = 1'b0;
        @(negedge clk);
        checkOutput("flush+start not busy", {31'd0, bus.div_stall}, 32'd0);
        @(posedge clk);
        #1;

        // Hold at DONE for 3 cycles: done and results stay put.
        bus.holdE = 1'b1;
        runAndCheck("hold", ALU_SIGNED_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            checkOutput($sformatf("hold cycle%0d done", c), {31'd0, bus.div_done}, 32'd1);
            checkOutput($sformatf("hold cycle%0d lo", c), bus.lo_out, 32'hFFFF_FFF2);
            checkOutput($sformatf("hold cycle%0d hi", c), bus.hi_out, 32'hFFFF_FFFE);
            @(posedge clk);
            #1;
        end
        bus.holdE = 1'b0;
        @(negedge clk);
        checkOutput("hold release done", {31'd0, bus.div_done}, 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("after hold idle done",  {31'd0, bus.div_done},  32'd0);
        checkOutput("after hold idle stall", {31'd0, bus.div_stall}, 32'd0);
        @(posedge clk);
        #1;
        runAndCheck("restart", ALU_SIGNED_DIV, 32'd50, 32'd7, 32'd7, 32'd1);

        // Non-divide codes never stall.
        bus.alu_controlE = ALU_ADD;
        bus.validE       = 1'b1;
        @(negedge clk);
        checkOutput("add stall", {31'd0, bus.div_stall}, 32'd0);
        @(posedge clk);
        #1;
        bus.alu_controlE = ALU_SIGNED_MULT;
        @(negedge clk);
        checkOutput("mult stall", {31'd0, bus.div_stall}, 32'd0);
        checkOutput("mult done",  {31'd0, bus.div_done},  32'd0);
        @(posedge clk);
        #1;
        bus.validE = 1'b0;
        @(negedge clk);
        checkOutput("after mult stall", {31'd0, bus.div_stall}, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        bus.alu_controlE = ALU_SIGNED_DIV;
        bus.srcaE        = 32'hFFFF_FF9C;
        bus.srcbE        = 32'd3;
        bus.validE       = 1'b1;
        @(posedge clk);
        #1;
        bus.validE = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midbusy stall", {31'd0, bus.div_stall}, 32'd1);
        checkOutput("midbusy lo before reset", bus.lo_out, 32'd7);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset stall", {31'd0, bus.div_stall}, 32'd0);
        checkOutput("async reset done",  {31'd0, bus.div_done},  32'd0);
        checkOutput("async reset hi",    bus.hi_out, 32'd0);
        checkOutput("async reset lo",    bus.lo_out, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        runAndCheck("post reset", ALU_UNSIGNED_DIV, 32'd1234567, 32'd1000, 32'd1234, 32'd567);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
